// File: rtl/seg7_mux_counter.sv
// seg7_mux_counter
//   Multi-digit BCD up/down counter with a programmable tick prescaler, pause,
//   clear and leading-zero blanking. The count is shown on a time-multiplexed
//   7-segment display, one digit at a time, on a shared segment bus.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset of every register
//   compare_sel  0 selects MAX_COUNT as the prescaler compare value, otherwise
//                the compare value is compare_sel * 1024
//   run          1 = count, 0 = pause (prescaler and count frozen)
//   up_down      1 = increment, 0 = decrement (sampled on the step cycle)
//   clear        zero count and prescaler; has priority over a step
//   segments     active-high {g..a} segments of the selected digit, 0 if blank
//   digit_sel    one-hot active-high digit enable
//   count_bcd    live count, digit 0 in [3:0]
//   tick         one-cycle pulse on each count update
//   wrap         one-cycle pulse when the count wraps
module seg7_mux_counter #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter logic [23:0] MAX_COUNT  = 24'd10_000_000,
   parameter logic [15:0] SCAN_DIV   = 16'd10_000,
   parameter bit          LEAD_BLANK = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              compare_sel,
   input  logic                    run,
   input  logic                    up_down,
   input  logic                    clear,
   output logic [6:0]              segments,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic [4*NUM_DIGITS-1:0] count_bcd,
   output logic                    tick,
   output logic                    wrap
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         default: seg7 = 7'h00;
      endcase
   endfunction

   logic [23:0]              presc_q, presc_d;
   logic [4*NUM_DIGITS-1:0]  count_q, count_d;
   logic                     tick_q, tick_d;
   logic                     wrap_q, wrap_d;
   logic [15:0]              scan_q, scan_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [NUM_DIGITS-1:0]    sel_q, sel_d;
   logic [6:0]               seg_q, seg_d;

   logic [23:0]              compare;
   logic [4*NUM_DIGITS-1:0]  count_step;
   logic                     step_wrap;
   logic [NUM_DIGITS-1:0]    blank;

   assign compare = (compare_sel == 8'd0) ? MAX_COUNT : {6'b0, compare_sel, 10'b0};

   // Ripple the +1/-1 through the digits; a carry/borrow that survives past
   // the top digit means every digit was 9 (up) or 0 (down), i.e. a wrap.
   always_comb begin
      logic       carry;
      logic [3:0] digit;
      count_step = count_q;
      carry      = 1'b1;
      digit      = 4'd0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         digit = count_q[4*k +: 4];
         if (carry) begin
            if (up_down) begin
               if (digit == 4'd9) begin
                  count_step[4*k +: 4] = 4'd0;
               end else begin
                  count_step[4*k +: 4] = digit + 4'd1;
                  carry                = 1'b0;
               end
            end else begin
               if (digit == 4'd0) begin
                  count_step[4*k +: 4] = 4'd9;
               end else begin
                  count_step[4*k +: 4] = digit - 4'd1;
                  carry                = 1'b0;
               end
            end
         end
      end
      step_wrap = carry;
   end

   // Prescaler and count. The >= compare lets compare_sel shrink below the
   // current prescaler value without running all the way round 2^24.
   always_comb begin
      presc_d = presc_q;
      count_d = count_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      if (clear) begin
         presc_d = 24'd0;
         count_d = '0;
      end else if (run) begin
         if (presc_q >= compare) begin
            presc_d = 24'd0;
            count_d = count_step;
            tick_d  = 1'b1;
            wrap_d  = step_wrap;
         end else begin
            presc_d = presc_q + 24'd1;
         end
      end
   end

   // Digit scan, free-running regardless of run and clear.
   always_comb begin
      scan_d = scan_q + 16'd1;
      idx_d  = idx_q;
      if (scan_q >= SCAN_DIV - 16'd1) begin
         scan_d = 16'd0;
         idx_d  = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // Digit k > 0 is blank when it and every higher digit are zero.
   always_comb begin
      logic higher_nz;
      higher_nz = 1'b0;
      blank     = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         higher_nz = higher_nz | (count_q[4*k +: 4] != 4'd0);
         blank[k]  = LEAD_BLANK && (k != 0) && !higher_nz;
      end
   end

   // Display registers lag index and count by one cycle.
   always_comb begin
      logic [3:0] cur_digit;
      logic       cur_blank;
      cur_digit = 4'd0;
      cur_blank = 1'b0;
      sel_d     = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            sel_d[k]  = 1'b1;
            cur_digit = count_q[4*k +: 4];
            cur_blank = blank[k];
         end
      end
      seg_d = cur_blank ? 7'h00 : seg7(cur_digit);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= 24'd0;
         count_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
         scan_q  <= 16'd0;
         idx_q   <= '0;
         sel_q   <= '0;
         seg_q   <= 7'h00;
      end else begin
         presc_q <= presc_d;
         count_q <= count_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         seg_q   <= seg_d;
      end
   end

   assign segments  = seg_q;
   assign digit_sel = sel_q;
   assign count_bcd = count_q;
   assign tick      = tick_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_seg7_mux_counter.sv
// Bench for seg7_mux_counter with two digits, fast prescaler and short scan.
module tb_seg7_mux_counter;

   localparam int          ND    = 2;
   localparam logic [23:0] MAXC  = 24'd4;
   localparam logic [15:0] SDIV  = 16'd3;
   localparam int          MODV  = 100;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [7:0]    compare_sel = 8'd0;
   logic          run = 1'b1;
   logic          up_down = 1'b1;
   logic          clear = 1'b0;
   logic [6:0]    segments;
   logic [ND-1:0] digit_sel;
   logic [4*ND-1:0] count_bcd;
   logic          tick;
   logic          wrap;

   int n_checks = 0;
   int n_err = 0;

   seg7_mux_counter #(
      .NUM_DIGITS(ND), .MAX_COUNT(MAXC), .SCAN_DIV(SDIV), .LEAD_BLANK(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .compare_sel(compare_sel), .run(run),
      .up_down(up_down), .clear(clear), .segments(segments),
      .digit_sel(digit_sel), .count_bcd(count_bcd), .tick(tick), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_code(input int d);
      case (d)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   function automatic int pow10(input int e);
      int p = 1;
      for (int i = 0; i < e; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [4*ND-1:0] to_bcd(input int n);
      logic [4*ND-1:0] r = '0;
      for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((n / pow10(i)) % 10);
      return r;
   endfunction

   // Digit idx of value n, blank when the value has no digit at that position.
   function automatic logic [6:0] exp_seg(input int n, input int idx);
      if (idx > 0 && n < pow10(idx)) return 7'h00;
      return seg_code((n / pow10(idx)) % 10);
   endfunction

   // Behavioural model: count held as a plain integer 0..MODV-1.
   bit          model_on = 1'b0;
   int          m_n = 0, m_pre = 0, m_scan = 0, m_idx = 0;
   logic [ND-1:0] m_sel = '0;
   logic [6:0]  m_seg = '0;
   logic        m_tick = 1'b0, m_wrap = 1'b0;

   always @(posedge clk) begin
      int cmp;
      if (reset) begin
         model_on = 1'b1;
         m_n = 0; m_pre = 0; m_scan = 0; m_idx = 0;
         m_sel = '0; m_seg = '0; m_tick = 1'b0; m_wrap = 1'b0;
      end else begin
         m_sel = ND'(1 << m_idx);
         m_seg = exp_seg(m_n, m_idx);
         if (m_scan == int'(SDIV) - 1) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % ND;
         end else begin
            m_scan++;
         end
         m_tick = 1'b0;
         m_wrap = 1'b0;
         if (clear) begin
            m_n = 0;
            m_pre = 0;
         end else if (run) begin
            cmp = (compare_sel == 8'd0) ? int'(MAXC) : int'(compare_sel) * 1024;
            if (m_pre >= cmp) begin
               m_pre  = 0;
               m_tick = 1'b1;
               if (up_down) begin
                  m_wrap = (m_n == MODV - 1);
                  m_n    = (m_n + 1) % MODV;
               end else begin
                  m_wrap = (m_n == 0);
                  m_n    = (m_n + MODV - 1) % MODV;
               end
            end else begin
               m_pre++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("model count_bcd", 32'(count_bcd), 32'(to_bcd(m_n)));
         check("model tick", 32'(tick), 32'(m_tick));
         check("model wrap", 32'(wrap), 32'(m_wrap));
         check("model digit_sel", 32'(digit_sel), 32'(m_sel));
         check("model segments", 32'(segments), 32'(m_seg));
      end
   end

   // Clocks from the current negedge until tick is seen (inclusive), bounded.
   task automatic wait_tick(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (tick !== 1'b1 && cyc < 3000);
      if (tick !== 1'b1) begin
         n_checks++;
         n_err++;
         $display("FAIL tick timeout: no tick within %0d clocks", cyc);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("reset count_bcd", 32'(count_bcd), 32'h0);
      check("reset digit_sel", 32'(digit_sel), 32'h0);
      check("reset segments", 32'(segments), 32'h0);
      check("reset tick", 32'(tick), 32'h0);
      check("reset wrap", 32'(wrap), 32'h0);
      reset = 1'b0;
   endtask

   initial begin
      int cyc;
      int ticks_seen;

      // Scan and blanking from a fresh reset.
      run = 1'b1; up_down = 1'b1; compare_sel = 8'd0; clear = 1'b0;
      do_reset();
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         check("scan digit_sel", 32'(digit_sel), (k <= 3 || k >= 7) ? 32'h1 : 32'h2);
         if (k == 1) check("units zero segments", 32'(segments), 32'h3F);
      end
      cyc = 0;
      while (count_bcd != 8'h05 && cyc < 10) begin
         wait_tick(ticks_seen);
         cyc++;
      end
      run = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (digit_sel == 2'b01) check("units five segments", 32'(segments), 32'h6D);
         else check("tens blank segments", 32'(segments), 32'h0);
      end
      run = 1'b1;

      // MAX_COUNT path, up count through a full wrap.
      do_reset();
      wait_tick(cyc);
      check("first tick latency", 32'(cyc), 32'd5);
      check("first count", 32'(count_bcd), 32'h01);
      for (int t = 2; t <= 100; t++) begin
         wait_tick(cyc);
         check("up tick period", 32'(cyc), 32'd5);
         if (t == 10) check("count at tick 10", 32'(count_bcd), 32'h10);
         if (t == 100) begin
            check("up wrap count", 32'(count_bcd), 32'h00);
            check("up wrap pulse", 32'(wrap), 32'h1);
         end
      end

      // Down wrap.
      up_down = 1'b0;
      do_reset();
      wait_tick(cyc);
      check("down wrap count", 32'(count_bcd), 32'h99);
      check("down wrap pulse", 32'(wrap), 32'h1);
      wait_tick(cyc);
      check("down count 98", 32'(count_bcd), 32'h98);
      wait_tick(cyc);
      check("down count 97", 32'(count_bcd), 32'h97);

      // Pause, then clear on the cycle a tick would occur.
      up_down = 1'b1;
      do_reset();
      for (int t = 0; t < 37; t++) wait_tick(cyc);
      check("count before pause", 32'(count_bcd), 32'h37);
      run = 1'b0;
      ticks_seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (tick) ticks_seen++;
      end
      check("ticks while paused", 32'(ticks_seen), 32'd0);
      check("count after pause", 32'(count_bcd), 32'h37);
      run = 1'b1;
      repeat (4) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      check("clear count", 32'(count_bcd), 32'h00);
      check("clear tick", 32'(tick), 32'h0);
      clear = 1'b0;
      wait_tick(cyc);
      check("tick after clear", 32'(cyc), 32'd5);

      // compare_sel path.
      compare_sel = 8'd1;
      wait_tick(cyc);
      check("compare_sel=1 period", 32'(cyc), 32'd1025);
      repeat (600) @(negedge clk);
      compare_sel = 8'd0;
      wait_tick(cyc);
      check("shrink compare step", 32'(cyc), 32'd1);
      wait_tick(cyc);
      check("period after shrink", 32'(cyc), 32'd5);

      // Randomised run/direction/clear, checked by the model every cycle.
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         run     = ($urandom_range(3) != 0);
         up_down = $urandom_range(1) == 1;
         clear   = ($urandom_range(39) == 0);
      end
      clear = 1'b0; run = 1'b1; up_down = 1'b1;

      // Reset in the middle of a count.
      do_reset();
      for (int t = 0; t < 42; t++) wait_tick(cyc);
      check("count before mid reset", 32'(count_bcd), 32'h42);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid reset count_bcd", 32'(count_bcd), 32'h0);
      check("mid reset digit_sel", 32'(digit_sel), 32'h0);
      check("mid reset segments", 32'(segments), 32'h0);
      check("mid reset tick", 32'(tick), 32'h0);
      reset = 1'b0;
      wait_tick(cyc);
      check("tick after mid reset", 32'(cyc), 32'd5);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/seg7_mux_counter.md
# seg7_mux_counter

Parametrised multi-digit decimal counter with time-multiplexed 7-segment drive. It supersedes the single-digit second counter. It counts up or down across NUM_DIGITS BCD digits at a programmable tick rate, with pause, clear and leading-zero blanking. It scans one digit at a time onto a shared segment bus and sits between the top-level switch inputs and the display/GPIO pins.

## Interface
- NUM_DIGITS, 4: number of BCD digits; legal range 1–8.
- MAX_COUNT, 24'd10_000_000: tick period (in clocks, minus 1) used when `compare_sel` == 0.
- SCAN_DIV, 16'd10_000: clocks each digit stays selected; must be ≥ 1.
- LEAD_BLANK, 1: when 1, blank leading zero digits; digit 0 is never blanked.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- compare_sel  in  8  0 selects MAX_COUNT; otherwise the compare value is {6'b0, compare_sel, 10'b0}.
- run  in  1  1 = count, 0 = pause (prescaler and count both frozen).
- up_down  in  1  1 = increment, 0 = decrement.
- clear  in  1  synchronous zero of count and prescaler.
- segments  out  7  active-high segments {g..a} of the selected digit, using the codebase seg7 encoding; all zero when blanked.
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable.
- count_bcd  out  4*NUM_DIGITS  live count; digit 0 (least significant) is in [3:0].
- tick  out  1  one-cycle pulse on each count update.
- wrap  out  1  one-cycle pulse when the count wraps.

## Operation
- Prescaler: 24-bit register. Each cycle with run=1:
  - if prescaler ≥ compare: prescaler ← 0 and a count step occurs;
  - else prescaler increments.
  - The ≥ test lets compare_sel shrink mid-count without a 2^24 runaway.
- Count step, up: increment digit 0. A digit at 9 becomes 0 and carries to the next digit. If all digits are 9, the count becomes all 0 and wrap=1.
- Count step, down: decrement digit 0. A digit at 0 becomes 9 and borrows from the next digit. If all digits are 0, the count becomes all 9 and wrap=1.
- Digit values are always 0–9. Non-BCD values are unreachable.
- clear=1: count ← 0, prescaler ← 0, tick and wrap forced 0. clear has priority over a coincident step. clear does not touch the scan logic.
- run=0: prescaler and count hold. tick and wrap stay 0. clear still acts.
- up_down is sampled only on the cycle of the step.
- Scan:
  - A scan counter runs from 0 to SCAN_DIV−1.
  - On wrap it advances the digit index 0 → NUM_DIGITS−1 → 0.
  - Scan is independent of run and clear.
- Blanking (LEAD_BLANK=1): digit k>0 is blank when digit k and every higher digit are 0.
- Display registers:
  - digit_sel ← one-hot(index).
  - segments ← seg7(count digit[index]), or 0 if that digit is blank.

## Timing
- Reset values: count_bcd=0, prescaler=0, scan counter=0, index=0, digit_sel=0, segments=0, tick=0, wrap=0.
- Tick period is compare+1 clocks while run=1 and compare is held constant.
- The new count_bcd, tick and wrap all become visible in the same cycle, one edge after the prescaler reaches compare.
- digit_sel and segments lag index and count by 1 cycle:
  - first cycle after reset: digit_sel=1, segments for digit 0;
  - a count change appears on segments 1 cycle after count_bcd.
- Reset asserted mid-operation returns every register to its reset value on that edge, overriding run and clear.

## Test plan
- Reset, then MAX_COUNT path. Parameters NUM_DIGITS=2, MAX_COUNT=4, SCAN_DIV=3; compare_sel=0, run=1, up_down=1.
  - tick every 5 clocks;
  - count_bcd steps 0x00, 0x01 … 0x09, 0x10;
  - after 100 ticks count_bcd=0x00 with wrap=1 on that tick only.
- Down wrap. From reset with up_down=0:
  - first tick gives count_bcd=0x99 and wrap=1;
  - next tick gives 0x98, then 0x97.
- Pause and clear.
  - run=0 for 20 clocks at count 0x37: count and prescaler frozen, no tick.
  - clear asserted on the exact cycle a tick would occur: count_bcd=0x00, tick=0, and the next tick arrives 5 clocks later.
- compare_sel.
  - compare_sel=1: tick period is 1025 clocks.
  - Change compare_sel 1→0 while prescaler=600: the step occurs on the next clock, then the period is 5.
- Scan and blanking with SCAN_DIV=3, LEAD_BLANK=1.
  - digit_sel cycles 01, 10, 01 with 3 clocks each.
  - At count 0x05: the tens digit gives segments=0 and the units digit gives the seg7 code for 5.
  - At count 0x00: the units digit shows the seg7 code for 0.
- Reset mid-count at count 0x42 with prescaler=3: on the next cycle all outputs equal their reset values, and the first tick arrives 5 clocks after reset deasserts.
